// File: rtl/byte_pack_fifo.sv
// Pairs incoming bytes little-endian into 16-bit words and buffers them in a DEPTH-word FWFT FIFO.
// input_enable comes from registered state and flush only; a pop frees space one cycle later.
module byte_pack_fifo #(
  parameter int          DEPTH    = 16,
  parameter logic [7:0]  PAD_BYTE = 8'h00
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     input_valid,
  output logic                     input_enable,
  input  logic [7:0]               data_in,
  input  logic                     flush,
  output logic                     output_valid,
  input  logic                     output_enable,
  output logic [15:0]              data_out,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     byte_pending
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  typedef enum logic {
    LOW_WAIT  = 1'b0,
    HIGH_WAIT = 1'b1
  } state_t;

  state_t          r_state;
  logic [7:0]      r_hold;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [LW-1:0]   r_level;
  logic [15:0]     r_mem [DEPTH];

  logic            w_pending;
  logic            w_full;
  logic            w_byte_acc;
  logic            w_flush_go;
  logic            w_push;
  logic            w_pop;
  logic [15:0]     w_push_word;

  assign w_pending    = (r_state == HIGH_WAIT);
  assign w_full       = (r_level == FULL_LVL);
  assign input_enable = !flush && !(w_pending && w_full);
  assign w_byte_acc   = input_valid && input_enable;
  // flush and a byte transfer are mutually exclusive because flush drops input_enable
  assign w_flush_go   = flush && w_pending && !w_full;
  assign w_push       = (w_byte_acc && w_pending) || w_flush_go;
  assign w_push_word  = w_flush_go ? {PAD_BYTE, r_hold} : {data_in, r_hold};

  assign output_valid = (r_level != '0);
  assign w_pop        = output_valid && output_enable;
  assign data_out     = output_valid ? r_mem[r_rd_ptr] : 16'h0000;
  assign level        = r_level;
  assign byte_pending = w_pending;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= LOW_WAIT;
      r_hold   <= 8'h00;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      case (r_state)
        LOW_WAIT: begin
          if (w_byte_acc) begin
            r_hold  <= data_in;
            r_state <= HIGH_WAIT;
          end
        end
        HIGH_WAIT: begin
          if (w_push) begin
            r_state <= LOW_WAIT;
          end
        end
        default: r_state <= LOW_WAIT;
      endcase

      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + LW'(1);
      end else if (w_pop && !w_push) begin
        r_level <= r_level - LW'(1);
      end
    end
  end

  // storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_word;
    end
  end

endmodule

// File: tb/tb_byte_pack_fifo.sv
// Directed bench for byte_pack_fifo: fill/full, drain, concurrent stream, flush, async reset, empty read.
module tb_byte_pack_fifo;

  logic        clk;
  logic        rst;
  logic        input_valid;
  logic        input_enable;
  logic [7:0]  data_in;
  logic        flush;
  logic        output_valid;
  logic        output_enable;
  logic [15:0] data_out;
  logic [4:0]  level;
  logic        byte_pending;

  int checks   = 0;
  int failures = 0;

  byte_pack_fifo #(.DEPTH(16), .PAD_BYTE(8'h00)) dut (
    .clk           (clk),
    .rst           (rst),
    .input_valid   (input_valid),
    .input_enable  (input_enable),
    .data_in       (data_in),
    .flush         (flush),
    .output_valid  (output_valid),
    .output_enable (output_enable),
    .data_out      (data_out),
    .level         (level),
    .byte_pending  (byte_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    input_valid = 1'b0;
    data_in = 8'h00;
    flush = 1'b0;
    output_enable = 1'b0;
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (output_valid !== 1'b0 || level !== 5'd0 || byte_pending !== 1'b0 ||
        data_out !== 16'h0000 || input_enable !== 1'b1) begin
      failures++;
      $display("FAIL reset_state: ov=%b level=%0d pend=%b dout=%h ie=%b, want 0 0 0 0000 1",
               output_valid, level, byte_pending, data_out, input_enable);
    end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 32; i++) begin
      input_valid = 1'b1;
      data_in = 8'(i);
      step();
    end
    input_valid = 1'b0;
    #1;
    checks++;
    if (level !== 5'd16 || byte_pending !== 1'b0 || input_enable !== 1'b1) begin
      failures++;
      $display("FAIL fill_16: level=%0d pend=%b ie=%b, want 16 0 1", level, byte_pending, input_enable);
    end
    input_valid = 1'b1;
    data_in = 8'hAA;
    step();
    input_valid = 1'b0;
    #1;
    checks++;
    if (byte_pending !== 1'b1 || input_enable !== 1'b0 || level !== 5'd16) begin
      failures++;
      $display("FAIL fill_extra_byte: pend=%b ie=%b level=%0d, want 1 0 16", byte_pending, input_enable, level);
    end
    input_valid = 1'b1;
    data_in = 8'hBB;
    step();
    input_valid = 1'b0;
    #1;
    checks++;
    if (byte_pending !== 1'b1 || level !== 5'd16 || input_enable !== 1'b0) begin
      failures++;
      $display("FAIL fill_refused: pend=%b level=%0d ie=%b, want 1 16 0", byte_pending, level, input_enable);
    end
  endtask

  task automatic test_drain();
    logic [15:0] exp;
    int bad;
    bad = 0;
    output_enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp = {8'(2 * i + 1), 8'(2 * i)};
      if (output_valid !== 1'b1 || data_out !== exp) begin
        bad++;
        $display("FAIL drain_word%0d: ov=%b dout=%h, want 1 %h", i, output_valid, data_out, exp);
      end
      step();
      if (i == 0) begin
        checks++;
        if (input_enable !== 1'b1) begin
          failures++;
          $display("FAIL drain_ie_rise: ie=%b, want 1", input_enable);
        end
      end
    end
    checks++;
    if (bad != 0) failures++;
    output_enable = 1'b0;
    checks++;
    if (output_valid !== 1'b0 || level !== 5'd0 || byte_pending !== 1'b1) begin
      failures++;
      $display("FAIL drain_empty: ov=%b level=%0d pend=%b, want 0 0 1", output_valid, level, byte_pending);
    end
  endtask

  task automatic test_concurrent();
    logic [7:0]  bytes [64];
    logic [15:0] exp;
    int sent, rcv, gap, max_lvl, bad, cyc;
    do_reset();
    for (int i = 0; i < 64; i++) bytes[i] = 8'(i * 7 + 3);
    sent = 0; rcv = 0; gap = 0; max_lvl = 0; bad = 0; cyc = 0;
    while ((sent < 64 || rcv < 32) && cyc < 3000) begin
      if (gap > 0 || sent >= 64) begin
        input_valid = 1'b0;
        if (gap > 0) gap--;
      end else begin
        input_valid = 1'b1;
        data_in = bytes[sent];
      end
      output_enable = 1'($urandom_range(0, 1));
      #1;
      if (int'(level) > max_lvl) max_lvl = int'(level);
      if (output_valid && output_enable) begin
        exp = (rcv < 32) ? {bytes[2 * rcv + 1], bytes[2 * rcv]} : 16'hxxxx;
        if (data_out !== exp) begin
          bad++;
          $display("FAIL stream_word%0d: dout=%h, want %h", rcv, data_out, exp);
        end
        rcv++;
      end
      if (input_valid && input_enable) begin
        sent++;
        gap = $urandom_range(0, 2);
      end
      step();
      cyc++;
    end
    input_valid = 1'b0;
    output_enable = 1'b0;
    #1;
    checks++;
    if (bad != 0) failures++;
    checks++;
    if (rcv != 32 || sent != 64 || level !== 5'd0) begin
      failures++;
      $display("FAIL stream_count: recv=%0d sent=%0d level=%0d, want 32 64 0", rcv, sent, level);
    end
    checks++;
    if (max_lvl > 16) begin
      failures++;
      $display("FAIL stream_max_level: got %0d, want <=16", max_lvl);
    end
  endtask

  task automatic test_flush();
    do_reset();
    input_valid = 1'b1;
    data_in = 8'h5A;
    step();
    input_valid = 1'b0;
    flush = 1'b1;
    #1;
    checks++;
    if (input_enable !== 1'b0) begin
      failures++;
      $display("FAIL flush_ie_low: ie=%b, want 0", input_enable);
    end
    step();
    flush = 1'b0;
    #1;
    checks++;
    if (output_valid !== 1'b1 || data_out !== 16'h005A || byte_pending !== 1'b0 || level !== 5'd1) begin
      failures++;
      $display("FAIL flush_word: ov=%b dout=%h pend=%b level=%0d, want 1 005a 0 1",
               output_valid, data_out, byte_pending, level);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    checks++;
    if (level !== 5'd1 || byte_pending !== 1'b0 || data_out !== 16'h005A) begin
      failures++;
      $display("FAIL flush_idle: level=%0d pend=%b dout=%h, want 1 0 005a", level, byte_pending, data_out);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      input_valid = 1'b1;
      data_in = 8'(8'h40 + i);
      step();
    end
    input_valid = 1'b0;
    #1;
    checks++;
    if (level !== 5'd3 || byte_pending !== 1'b1 || data_out !== 16'h4140) begin
      failures++;
      $display("FAIL pre_reset: level=%0d pend=%b dout=%h, want 3 1 4140", level, byte_pending, data_out);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (output_valid !== 1'b0 || level !== 5'd0 || byte_pending !== 1'b0 || data_out !== 16'h0000) begin
      failures++;
      $display("FAIL async_reset: ov=%b level=%0d pend=%b dout=%h, want 0 0 0 0000",
               output_valid, level, byte_pending, data_out);
    end
    #1;
    rst = 1'b0;
    input_valid = 1'b1;
    data_in = 8'h11;
    step();
    data_in = 8'h22;
    step();
    input_valid = 1'b0;
    #1;
    checks++;
    if (output_valid !== 1'b1 || data_out !== 16'h2211 || level !== 5'd1) begin
      failures++;
      $display("FAIL post_reset_word: ov=%b dout=%h level=%0d, want 1 2211 1", output_valid, data_out, level);
    end
  endtask

  task automatic test_empty_read();
    do_reset();
    output_enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (output_valid !== 1'b0 || data_out !== 16'h0000 || level !== 5'd0) begin
        failures++;
        $display("FAIL empty_read%0d: ov=%b dout=%h level=%0d, want 0 0000 0",
                 i, output_valid, data_out, level);
      end
      step();
    end
    output_enable = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    input_valid = 1'b0;
    data_in = 8'h00;
    flush = 1'b0;
    output_enable = 1'b0;
    test_reset();
    test_fill();
    test_drain();
    test_concurrent();
    test_flush();
    test_async_reset();
    test_empty_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
